// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the core MEM stage and a debug/loader port.
// The core path is a combinational pass-through; debug accesses are slotted in by a small FSM.
//
//   state   | meaning
//   CORE    | memory owned by core; starvation counter tracks waiting debug request
//   ISSUE   | debug access on memory port; busy core stalled, its request held
//   CAPTURE | held core access executes; debug read data captured, ack raised
module data_memory_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [XLEN-1:0]       core_write_data,
  input  logic                  core_write_enable,
  input  logic                  core_read_enable,
  output logic [XLEN-1:0]       core_read_data,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_address,
  input  logic [XLEN-1:0]       dbg_write_data,
  output logic                  dbg_ack,
  output logic [XLEN-1:0]       dbg_read_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_wren,
  input  logic [XLEN-1:0]       mem_q
);

  localparam logic [1:0] ST_CORE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             issue_we;
  logic             core_busy;
  logic             dbg_pend;
  logic             grant;

  assign core_busy = core_read_enable | core_write_enable;
  // The ack cycle masks the still-high request so one request yields one access.
  assign dbg_pend  = dbg_req & ~dbg_ack;
  assign grant     = dbg_pend & (~core_busy | (starve_cnt == CNT_MAX));

  assign core_read_data = mem_q;

  always_comb begin
    state_next = state;
    case (state)
      ST_CORE:    if (grant) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_CORE;
      default:    state_next = ST_CORE;
    endcase
  end

  always_comb begin
    mem_address = core_address;
    mem_data    = core_write_data;
    mem_wren    = core_write_enable;
    core_stall  = 1'b0;
    if (state == ST_ISSUE) begin
      mem_address = dbg_address;
      mem_data    = dbg_write_data;
      mem_wren    = dbg_we;
      core_stall  = core_busy;
    end
    // An in-flight write must not land while reset is asserted.
    if (reset) begin
      mem_wren   = 1'b0;
      core_stall = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_CORE;
      starve_cnt    <= '0;
      issue_we      <= 1'b0;
      dbg_ack       <= 1'b0;
      dbg_read_data <= '0;
    end else begin
      state   <= state_next;
      dbg_ack <= 1'b0;
      case (state)
        ST_CORE: begin
          if (grant)
            starve_cnt <= '0;
          else if (dbg_pend && core_busy)
            starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
          else
            starve_cnt <= '0;
        end
        ST_ISSUE: begin
          starve_cnt <= '0;
          issue_we   <= dbg_we;
        end
        ST_CAPTURE: begin
          starve_cnt <= '0;
          dbg_ack    <= 1'b1;
          if (!issue_we)
            dbg_read_data <= mem_q;
        end
        default: starve_cnt <= '0;
      endcase
    end
  end

endmodule
